// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, signed or unsigned.
// Latency: done N+1 cycles after the start-accept edge; 1 cycle for early divide-by-zero/overflow.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or finishing.
module seq_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           done,
  output logic           busy,
  output logic           dbz,
  output logic           ovf
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  // Largest quotient magnitude representable for a positive / negative signed result
  localparam logic [N-1:0]  POS_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  NEG_MAX  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_FIN
  } state_t;

  state_t        state;

  // Working registers: partial remainder is one bit wider than the divisor
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dv_mag_q;
  logic [N-1:0]  dd_lo_q;
  logic          sgn_q;
  logic          dd_neg_q;
  logic          dv_neg_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  // Operand magnitudes, computed from the live inputs for use at the accept edge
  logic          in_dd_neg;
  logic          in_dv_neg;
  logic [2*N-1:0] in_dd_mag;
  logic [N-1:0]  in_dv_mag;

  // Restoring-step datapath
  logic [N+1:0]  trial;
  logic [N:0]    kept;
  logic [N:0]    rem_nxt;
  logic [N-1:0]  quo_nxt;

  // Sign fix-up datapath
  logic          q_neg;
  logic          sgn_ovf;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  // Magnitudes of the incoming operands; unsigned operands pass straight through
  always_comb begin
    in_dd_neg = is_signed & dividend[2*N-1];
    in_dv_neg = is_signed & divisor[N-1];
    in_dd_mag = in_dd_neg ? -dividend : dividend;
    in_dv_mag = in_dv_neg ? -divisor : divisor;
  end

  // One restoring step: shift {R,Q} left, trial-subtract, keep or restore
  always_comb begin
    // rem_q is always below the divisor, so the shifted value never exceeds N+1 bits
    trial = {rem_q, quo_q[N-1]} - {2'b00, dv_mag_q};
    kept  = {rem_q[N-1:0], quo_q[N-1]};
    if (trial[N+1]) begin
      rem_nxt = kept;
      quo_nxt = {quo_q[N-2:0], 1'b0};
    end else begin
      rem_nxt = trial[N:0];
      quo_nxt = {quo_q[N-2:0], 1'b1};
    end
  end

  // Truncating-division sign rules and signed range check on the raw magnitudes
  always_comb begin
    q_neg   = dd_neg_q ^ dv_neg_q;
    sgn_ovf = sgn_q & (q_neg ? (quo_q > NEG_MAX) : (quo_q > POS_MAX));
    q_fix   = q_neg ? -quo_q : quo_q;
    r_fix   = dd_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
  end

  // Control FSM with registered results and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dv_mag_q  <= '0;
      dd_lo_q   <= '0;
      sgn_q     <= 1'b0;
      dd_neg_q  <= 1'b0;
      dv_neg_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn_q    <= is_signed;
            dd_neg_q <= in_dd_neg;
            dv_neg_q <= in_dv_neg;
            rem_q    <= {1'b0, in_dd_mag[2*N-1:N]};
            quo_q    <= in_dd_mag[N-1:0];
            dv_mag_q <= in_dv_mag;
            dd_lo_q  <= dividend[N-1:0];
            cnt_q    <= CNT_LAST;
            busy     <= 1'b1;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            err_q    <= 1'b0;
            // Early exits skip the iteration; divide-by-zero wins over overflow.
            // They pass through FIX so the result lands one edge later like a normal finish.
            if (in_dv_mag == '0) begin
              dbz   <= 1'b1;
              err_q <= 1'b1;
              state <= S_FIX;
            end else if (in_dd_mag[2*N-1:N] >= in_dv_mag) begin
              ovf   <= 1'b1;
              err_q <= 1'b1;
              state <= S_FIX;
            end else begin
              state <= S_DIV;
            end
          end
        end

        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (err_q || sgn_ovf) begin
            quotient  <= '1;
            remainder <= dd_lo_q;
            if (!err_q) begin
              ovf <= 1'b1;
            end
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_FIN;
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
